// File: rtl/ram_access_ctrl.sv
// Load/store sequencer between the core request port and a 16x4 synchronous RAM.
// Optional full-memory clear sequence enabled by defining CLR_SEQ_EN.
module ram_access_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_we,
    output logic [DATA_W-1:0] resp_data,
    output logic              ram_csn,
    output logic              ram_rwn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              clr_start,
    output logic              clr_busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACCESS  = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_RESP    = 3'd3;
`ifdef CLR_SEQ_EN
    localparam logic [2:0] S_CLEAR   = 3'd4;
`endif

    logic [2:0]        state_q, state_d;
    logic              ram_csn_q, ram_csn_d;
    logic              ram_rwn_q, ram_rwn_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_we_q, resp_we_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              clr_busy_q, clr_busy_d;
`ifdef CLR_SEQ_EN
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`else
    logic              clr_start_unused;
    assign clr_start_unused = clr_start;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        ram_csn_d    = ram_csn_q;
        ram_rwn_d    = ram_rwn_q;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        resp_valid_d = resp_valid_q;
        resp_we_d    = resp_we_q;
        resp_data_d  = resp_data_q;
        clr_busy_d   = clr_busy_q;
`ifdef CLR_SEQ_EN
        clr_cnt_d    = clr_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef CLR_SEQ_EN
                if (clr_start) begin
                    state_d    = S_CLEAR;
                    clr_busy_d = 1'b1;
                    ram_csn_d  = 1'b0;
                    ram_rwn_d  = 1'b0;
                    ram_din_d  = '0;
                    ram_addr_d = '0;
                    clr_cnt_d  = '0;
                end else
`endif
                if (req_valid) begin
                    state_d    = S_ACCESS;
                    ram_csn_d  = 1'b0;
                    ram_rwn_d  = ~req_we;
                    ram_addr_d = req_addr;
                    ram_din_d  = req_wdata;
                end
            end
            S_ACCESS: begin
                ram_csn_d = 1'b1;
                ram_rwn_d = 1'b1;
                ram_din_d = '0;
                // ram_rwn_q still carries the accepted operation type
                if (!ram_rwn_q) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_we_d    = 1'b1;
                    resp_data_d  = '0;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // RAM output is zeroed on this edge; capture the pre-edge value
                state_d      = S_RESP;
                resp_data_d  = ram_dout;
                resp_valid_d = 1'b1;
                resp_we_d    = 1'b0;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    resp_data_d  = '0;
                end
            end
`ifdef CLR_SEQ_EN
            S_CLEAR: begin
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d    = S_IDLE;
                    ram_csn_d  = 1'b1;
                    ram_rwn_d  = 1'b1;
                    clr_busy_d = 1'b0;
                end else begin
                    clr_cnt_d  = clr_cnt_q + ADDR_W'(1);
                    ram_addr_d = clr_cnt_q + ADDR_W'(1);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ram_csn_q    <= 1'b1;
            ram_rwn_q    <= 1'b1;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_we_q    <= 1'b0;
            resp_data_q  <= '0;
            clr_busy_q   <= 1'b0;
`ifdef CLR_SEQ_EN
            clr_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ram_csn_q    <= ram_csn_d;
            ram_rwn_q    <= ram_rwn_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            resp_valid_q <= resp_valid_d;
            resp_we_q    <= resp_we_d;
            resp_data_q  <= resp_data_d;
            clr_busy_q   <= clr_busy_d;
`ifdef CLR_SEQ_EN
            clr_cnt_q    <= clr_cnt_d;
`endif
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_we    = resp_we_q;
    assign resp_data  = resp_data_q;
    assign ram_csn    = ram_csn_q;
    assign ram_rwn    = ram_rwn_q;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;
    assign clr_busy   = clr_busy_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural 16x4 synchronous RAM.
// Clear-sequence checks are built only when CLR_SEQ_EN is defined.
module tb_ram_access_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_we;
    logic [3:0] req_addr, req_wdata;
    logic       resp_valid, resp_ready, resp_we;
    logic [3:0] resp_data;
    logic       ram_csn, ram_rwn;
    logic [3:0] ram_addr, ram_din, ram_dout;
    logic       clr_start, clr_busy;

    int tests  = 0;
    int failed = 0;

    logic [3:0] mem [16];

    always #5 clk = ~clk;

    ram_access_ctrl #(.ADDR_W(4), .DATA_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_we(resp_we),
        .resp_data(resp_data),
        .ram_csn(ram_csn), .ram_rwn(ram_rwn), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .clr_start(clr_start), .clr_busy(clr_busy)
    );

    // RAM: registered read, output zeroed whenever not performing a read
    always @(posedge clk) begin
        if (!ram_csn && !ram_rwn) mem[ram_addr] <= ram_din;
        if (!ram_csn && ram_rwn) ram_dout <= mem[ram_addr];
        else                     ram_dout <= 4'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("wr_csn", 32'(ram_csn), 32'd0);
        chk("wr_addr", 32'(ram_addr), 32'(a));
        tick();
        chk("wr_ack", 32'(resp_valid), 32'd1);
        tick();
        chk("wr_idle", 32'(req_ready), 32'd1);
    endtask

    task automatic do_read(input string tag, input logic [3:0] a, input logic [3:0] exp);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk({tag, "_rwn"}, 32'(ram_rwn), 32'd1);
        tick();
        chk({tag, "_novalid"}, 32'(resp_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_we"}, 32'(resp_we), 32'd0);
        chk({tag, "_data"}, 32'(resp_data), 32'(exp));
        tick();
        chk({tag, "_done"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'h0;
        ram_dout = 4'h0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 4'h0;
        req_wdata = 4'h0; resp_ready = 1'b0; clr_start = 1'b0;
        tick();
        tick();
        chk("rst_csn", 32'(ram_csn), 32'd1);
        chk("rst_rwn", 32'(ram_rwn), 32'd1);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_outs", {16'h0, ram_addr, ram_din, resp_data, 3'b0, resp_we}, 32'd0);
        chk("rst_busy", 32'(clr_busy), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_csn", 32'(ram_csn), 32'd1);

        // Write 0xA to address 5, cycle by cycle
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 4'hA; resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("w5_ctl", {28'h0, ram_csn, ram_rwn, req_ready, resp_valid}, 32'b0000);
        chk("w5_addr", 32'(ram_addr), 32'd5);
        chk("w5_din", 32'(ram_din), 32'hA);
        tick();
        chk("w5_resp", {29'h0, resp_valid, resp_we, ram_csn}, 32'b111);
        chk("w5_rdata", 32'(resp_data), 32'h0);
        chk("w5_din0", 32'(ram_din), 32'h0);
        tick();
        chk("w5_back", {30'h0, resp_valid, req_ready}, 32'b01);

        do_read("rd5", 4'd5, 4'hA);
        do_read("rd3", 4'd3, 4'h0);

        // Read 5 with response back-pressure; stray requests must be ignored
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 4'h6;
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_data", 32'(resp_data), 32'hA);
            chk("bp_ready", 32'(req_ready), 32'd0);
            tick();
            chk("bp_csn", 32'(ram_csn), 32'd1);
        end
        req_valid = 1'b0;
        chk("bp_hold", 32'(resp_data), 32'hA);
        resp_ready = 1'b1;
        tick();
        chk("bp_release", {30'h0, resp_valid, req_ready}, 32'b01);
        chk("bp_rdata0", 32'(resp_data), 32'h0);
        do_read("rd3b", 4'd3, 4'h0);

        // Reset during the access cycle of a write to address 9
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd9; req_wdata = 4'h7;
        tick();
        req_valid = 1'b0;
        chk("ra_csn", 32'(ram_csn), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("ra_csn_rst", 32'(ram_csn), 32'd1);
        chk("ra_outs", {20'h0, ram_addr, ram_din, 2'b0, ram_rwn, resp_valid}, 32'b10);
        chk("ra_ready", 32'(req_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ra_noresp", 32'(resp_valid), 32'd0);
        do_read("rd9", 4'd9, 4'h0);

`ifdef CLR_SEQ_EN
        do_write(4'd0, 4'hF);
        do_write(4'd15, 4'hF);
        do_read("rd0f", 4'd0, 4'hF);
        // Clear start wins over a simultaneous write request to address 2
        clr_start = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd2; req_wdata = 4'h5;
        tick();
        clr_start = 1'b0; req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("clr_busy", 32'(clr_busy), 32'd1);
            chk("clr_ctl", {29'h0, ram_csn, ram_rwn, req_ready}, 32'b000);
            chk("clr_addr", 32'(ram_addr), 32'(i));
            chk("clr_din", 32'(ram_din), 32'h0);
            clr_start = (i == 6);
            tick();
        end
        clr_start = 1'b0;
        chk("clr_end", {29'h0, clr_busy, ram_csn, req_ready}, 32'b011);
        chk("clr_noresp", 32'(resp_valid), 32'd0);
        do_read("rdc0", 4'd0, 4'h0);
        do_read("rdc15", 4'd15, 4'h0);
        do_read("rdc2", 4'd2, 4'h0);
`else
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        chk("noclr_busy", 32'(clr_busy), 32'd0);
        chk("noclr_csn", 32'(ram_csn), 32'd1);
        chk("noclr_ready", 32'(req_ready), 32'd1);
        do_write(4'd0, 4'hF);
        do_read("rd0f", 4'd0, 4'hF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
